uart_auth: RTL

- Receives the 8N1 serial command stream from the BLE module on RX and decodes it.
- Owns the Segway's power authorization: 'G' (0x47) powers the platform up; 'S' (0x53) powers it down once the rider has stepped off.
- Sits directly downstream of the host-side UART transmitter. Its pwr_up output feeds the balance controller enable and the steering-enable logic in the Segway top level.
- Contains a UART receiver datapath plus an authorization FSM.

---
 rtl/uart_auth.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_auth.sv
// 8N1 UART receiver for the BLE command stream plus the power-authorization FSM.
// 'G' powers the platform up; 'S' powers it down once the rider has stepped off.
module uart_auth #(
    parameter int         BAUD_DIV = 5208,
    parameter logic [7:0] G_CMD    = 8'h47,
    parameter logic [7:0] S_CMD    = 8'h53
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    localparam logic [15:0] HALF = 16'(BAUD_DIV / 2);
    localparam logic [15:0] FULL = 16'(BAUD_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

    logic        rx_s1, rx_sync;
    rx_state_t   rx_st, rx_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [8:0]  shreg, sh_nxt;
    logic [3:0]  bits, bits_nxt;
    logic [7:0]  data_nxt;
    logic        rdy_nxt, ferr_nxt;
    logic        expire;

    auth_state_t au_st, au_nxt;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_sync <= rx_s1;
        end
    end

    assign expire = (cnt == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st   <= IDLE;
            cnt     <= 16'd0;
            shreg   <= 9'd0;
            bits    <= 4'd0;
            rx_data <= 8'h00;
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            rx_st   <= rx_nxt;
            cnt     <= cnt_nxt;
            shreg   <= sh_nxt;
            bits    <= bits_nxt;
            rx_data <= data_nxt;
            rx_rdy  <= rdy_nxt;
            frm_err <= ferr_nxt;
        end
    end

    always_comb begin
        rx_nxt   = rx_st;
        cnt_nxt  = cnt - 16'd1;
        sh_nxt   = shreg;
        bits_nxt = bits;
        data_nxt = rx_data;
        rdy_nxt  = 1'b0;
        ferr_nxt = 1'b0;
        case (rx_st)
            IDLE: begin
                cnt_nxt = cnt;
                if (!rx_sync) begin
                    rx_nxt  = START;
                    cnt_nxt = HALF;
                end
            end
            START: begin
                if (expire) begin
                    if (rx_sync) begin
                        rx_nxt = IDLE;
                    end else begin
                        rx_nxt   = DATA;
                        cnt_nxt  = FULL;
                        bits_nxt = 4'd0;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    sh_nxt   = {rx_sync, shreg[8:1]};
                    bits_nxt = bits + 4'd1;
                    cnt_nxt  = FULL;
                    if (bits == 4'd7) rx_nxt = STOP;
                end
            end
            STOP: begin
                if (expire) begin
                    // Back to IDLE right away so an abutting start bit is caught.
                    rx_nxt = IDLE;
                    if (rx_sync) begin
                        data_nxt = shreg[8:1];
                        rdy_nxt  = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            default: rx_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            au_st  <= OFF;
            pwr_up <= 1'b0;
        end else begin
            au_st  <= au_nxt;
            pwr_up <= (au_nxt != OFF);
        end
    end

    always_comb begin
        au_nxt = au_st;
        case (au_st)
            OFF:  if (rx_rdy && rx_data == G_CMD) au_nxt = PWR1;
            PWR1: if (rx_rdy && rx_data == S_CMD) au_nxt = rider_off ? OFF : PWR2;
            PWR2: begin
                // A fresh 'G' beats a coincident dismount.
                if (rx_rdy && rx_data == G_CMD) au_nxt = PWR1;
                else if (rider_off)             au_nxt = OFF;
            end
            default: au_nxt = OFF;
        endcase
    end

endmodule
